program_counter: RTL and testbench

- Single-cycle CPU program counter register holding the byte address of the current instruction.
- Advances by one 32-bit instruction word (4 bytes) every rising clock edge.
- Forced to the reset vector whenever reset is high.
- Its output feeds the instruction memory address port and the PC+4 / branch-target datapath.

---
 rtl/program_counter_if.sv | 10 +
 rtl/program_counter.sv | 27 ++
 tb/tb_program_counter.sv | 90 +++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Program-counter bus: the current instruction byte address, driven by the PC
// and consumed by instruction fetch and the next-PC datapath.
interface program_counter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc;

  modport master (output pc);
  modport slave  (input  pc);
endinterface

// File: rtl/program_counter.sv
// Single-cycle CPU program counter: advances by STEP bytes every rising edge,
// forced asynchronously to RESET_VALUE while reset is high.
module program_counter #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STEP        = 4
) (
  input  logic               clock,
  input  logic               reset,
  program_counter_if.master  pc_if
);

  // The declaration value gives a defined PC at power-up even when reset is never pulsed.
  logic [WIDTH-1:0] r_pc = RESET_VALUE;
  logic [WIDTH-1:0] w_pc_next;

  // Wraps modulo 2^WIDTH by truncation; there is no overflow flag.
  assign w_pc_next = r_pc + WIDTH'(STEP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pc <= RESET_VALUE;
    else       r_pc <= w_pc_next;
  end

  assign pc_if.pc = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: power-up free-run, async reset, held reset,
// reset coincident with an edge, and address wrap with a high reset vector.
module tb_program_counter;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic reset_w = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  program_counter_if #(.WIDTH(WIDTH)) pc_a ();
  program_counter_if #(.WIDTH(WIDTH)) pc_w ();

  program_counter #(.WIDTH(WIDTH), .RESET_VALUE(32'h0000_0000), .STEP(4)) u_dut (
    .clock (clock),
    .reset (reset),
    .pc_if (pc_a.master)
  );

  program_counter #(.WIDTH(WIDTH), .RESET_VALUE(32'hFFFF_FFF8), .STEP(4)) u_dut_wrap (
    .clock (clock),
    .reset (reset_w),
    .pc_if (pc_w.master)
  );

  always #50 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    // Power-up without reset: defined zero before the first edge at 50 ns.
    #10;
    chk("powerup", pc_a.pc, 32'h0);

    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("freerun", pc_a.pc, 32'(4 * k));
    end

    // t = 500 ns, between edges: reset takes effect with no clock.
    reset = 1'b1;
    #1;
    chk("async_rst", pc_a.pc, 32'h0);

    repeat (10) begin
      @(negedge clock);
      chk("rst_hold", pc_a.pc, 32'h0);
    end

    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("release", pc_a.pc, 32'(4 * k));
    end

    // Reset rising exactly on a clock edge while pc = 16: reset wins.
    @(posedge clock);
    reset = 1'b1;
    #1;
    chk("coincident", pc_a.pc, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("after_coinc", pc_a.pc, 32'h4);

    // High reset vector: wraps through zero.
    chk("wrap_rst", pc_w.pc, 32'hFFFF_FFF8);
    reset_w = 1'b0;
    @(negedge clock);
    chk("wrap_1", pc_w.pc, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap_2", pc_w.pc, 32'h0000_0000);
    @(negedge clock);
    chk("wrap_3", pc_w.pc, 32'h0000_0004);
    chk("align", {30'h0, pc_w.pc[1:0]}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
